// File: rtl/chicken_turn_sched_pkg.sv
// Shared constants for the chicken game sequencer: mode codes, player index
// width helper and default cycle counts for a 100 MHz clock.
package chicken_turn_sched_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'b000,
        TURN_START = 3'b001,
        WAIT_FLIP  = 3'b010,
        COMPARE    = 3'b011,
        MOVE       = 3'b100,
        REVEAL     = 3'b101,
        PASS       = 3'b110,
        GAMEOVER   = 3'b111
    } mode_t;

    localparam int unsigned DEF_NUM_PLAYERS = 4;
    localparam int unsigned DEF_CNT_W       = 28;
    localparam int unsigned DEF_TIMEOUT_CYC = 150000000;
    localparam int unsigned DEF_REVEAL_CYC  = 50000000;
    localparam int unsigned DEF_PASS_CYC    = 100000000;

    // Player index width, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_PW = idx_width(DEF_NUM_PLAYERS);

endpackage

// File: rtl/chicken_turn_sched_phase_timer.sv
// Per-phase cycle timer: cleared on every phase change, counts while enabled,
// and flags the last cycle of the phase against a muxed limit.
module chicken_turn_sched_phase_timer #(
    parameter int unsigned CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Count up while enabled; saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en && (count != '1))
            count <= count + CNT_W'(1);
    end

    // Terminal count: this is the final cycle of the timed phase.
    always_comb begin
        done = en && (count == (limit - CNT_W'(1)));
    end

endmodule

// File: rtl/chicken_turn_sched.sv
// Game-phase sequencer: drives the mode bus M, rotates turns round-robin and
// steps each turn through flip, compare, reveal, move and pass phases.
module chicken_turn_sched
    import chicken_turn_sched_pkg::*;
#(
    parameter  int unsigned NUM_PLAYERS = DEF_NUM_PLAYERS,
    parameter  int unsigned CNT_W       = DEF_CNT_W,
    parameter  int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter  int unsigned REVEAL_CYC  = DEF_REVEAL_CYC,
    parameter  int unsigned PASS_CYC    = DEF_PASS_CYC,
    localparam int unsigned PW          = idx_width(NUM_PLAYERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [NUM_PLAYERS-1:0] flip_req,
    input  logic                   match_vld,
    input  logic                   match,
    input  logic                   move_done,
    input  logic                   win,
    output logic [2:0]             M,
    output logic [PW-1:0]          active_player,
    output logic                   flip_ack,
    output logic                   move_en,
    output logic                   timeout,
    output logic [PW-1:0]          winner
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] REVEAL_LIM  = CNT_W'(REVEAL_CYC);
    localparam logic [CNT_W-1:0] PASS_LIM    = CNT_W'(PASS_CYC);
    localparam logic [PW-1:0]    LAST_PLAYER = PW'(NUM_PLAYERS - 1);

    mode_t            state, state_nxt;
    logic             matched;
    logic             move_first;
    logic             flip_hit;
    logic             tmr_en;
    logic             tmr_done;
    logic [CNT_W-1:0] tmr_limit;

    assign M        = state;
    assign flip_hit = flip_req[active_player];

    chicken_turn_sched_phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_nxt != state),
        .en    (tmr_en),
        .limit (tmr_limit),
        .done  (tmr_done)
    );

    // State register; move_first marks the entry cycle of MOVE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            move_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            move_first <= (state_nxt == MOVE) && (state != MOVE);
        end
    end

    // Next-state selection for the turn sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = TURN_START;
            TURN_START: state_nxt = WAIT_FLIP;
            WAIT_FLIP: begin
                if (flip_hit)      state_nxt = COMPARE;
                else if (tmr_done) state_nxt = PASS;
            end
            COMPARE:    if (match_vld) state_nxt = REVEAL;
            REVEAL:     if (tmr_done) state_nxt = matched ? MOVE : PASS;
            MOVE:       if (move_done) state_nxt = win ? GAMEOVER : WAIT_FLIP;
            PASS:       if (tmr_done) state_nxt = TURN_START;
            GAMEOVER:   if (start) state_nxt = TURN_START;
            default:    state_nxt = IDLE;
        endcase
    end

    // Pulse outputs and timer targeting for the current phase.
    always_comb begin
        flip_ack  = 1'b0;
        timeout   = 1'b0;
        move_en   = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = '0;
        case (state)
            WAIT_FLIP: begin
                tmr_en    = 1'b1;
                tmr_limit = TIMEOUT_LIM;
                flip_ack  = flip_hit;
                timeout   = tmr_done && !flip_hit;
            end
            REVEAL: begin
                tmr_en    = 1'b1;
                tmr_limit = REVEAL_LIM;
            end
            PASS: begin
                tmr_en    = 1'b1;
                tmr_limit = PASS_LIM;
            end
            MOVE:    move_en = move_first;
            default: ;
        endcase
    end

    // Turn pointer, match flag and winner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_player <= '0;
            winner        <= '0;
            matched       <= 1'b0;
        end else begin
            if (((state == IDLE) || (state == GAMEOVER)) && start)
                active_player <= '0;
            else if ((state == PASS) && tmr_done)
                active_player <= (active_player == LAST_PLAYER) ? '0
                                 : active_player + PW'(1);

            if ((state == GAMEOVER) && start)
                winner <= '0;
            else if ((state == MOVE) && move_done && win)
                winner <= active_player;

            if ((state == COMPARE) && match_vld)
                matched <= match;
        end
    end

endmodule
